sprite_cmd_queue: RTL and testbench

//  Elastic buffer between the game processor's sprite command stream and the graphics sprite renderer.

---
 rtl/sprite_cmd_queue.sv | 122 ++++++++++++
 tb/tb_sprite_cmd_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_cmd_queue.sv
// Elastic queue between the game processor's sprite command stream and the sprite renderer.
// Show-ahead registered head, range-checked pushes, and per-frame fencing on new_frame.
module sprite_cmd_queue #(
  parameter int CANVAS_WIDTH       = 360,
  parameter int CANVAS_HEIGHT      = 720,
  parameter int NUM_FRAMES         = 18,
  parameter int DEPTH              = 64,
  parameter bit FLUSH_ON_NEW_FRAME = 1'b1,
  localparam int XW = $clog2(CANVAS_WIDTH),
  localparam int YW = $clog2(CANVAS_HEIGHT),
  localparam int FW = $clog2(NUM_FRAMES),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_pixel,
  input  logic          rst_n_in,
  input  logic          new_frame,
  input  logic          wr_valid,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [FW-1:0] wr_frame,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  output logic [FW-1:0] rd_frame,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          bad_cmd,
  output logic [AW:0]   flushed_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [FW-1:0] f;
    logic [YW-1:0] y;
    logic [XW-1:0] x;
  } cmd_t;

  typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          wr_cmd, head_q, head_d;
  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_base;
  logic [AW:0]   cnt_q, cnt_d, cnt_base, flushed_q, flushed_d;
  logic          ovf_q, ovf_d, bad_q, bad_d;
  logic          flush, in_range, pop, push, drop;

  assign wr_cmd = '{f: wr_frame, y: wr_y, x: wr_x};

  always_comb begin
    flush    = new_frame && FLUSH_ON_NEW_FRAME;
    in_range = ({1'b0, wr_x} < (XW+1)'(CANVAS_WIDTH)) &&
               ({1'b0, wr_y} < (YW+1)'(CANVAS_HEIGHT)) &&
               ({1'b0, wr_frame} < (FW+1)'(NUM_FRAMES));
    // A flush empties the queue first, so a same-cycle push always lands as the sole entry.
    pop      = (state_q != EMPTY) && rd_ready && !flush;
    cnt_base = flush ? '0 : cnt_q;
    rd_base  = flush ? wr_ptr_q : rd_ptr_q;
    push     = wr_valid && in_range && ((cnt_base != FULL_CNT) || pop);
    drop     = wr_valid && in_range && !push;
    rd_ptr_d = rd_base + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    cnt_d    = cnt_base + (AW+1)'(push) - (AW+1)'(pop);

    // Head slot collides with the incoming write only when the queue drains to empty.
    head_d = head_q;
    if (cnt_d != '0)
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? wr_cmd : mem[rd_ptr_d];

    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = ACTIVE;
      ACTIVE:  if (cnt_d == FULL_CNT) state_d = FULL;
               else if (cnt_d == '0) state_d = EMPTY;
      FULL:    if (pop && !push) state_d = ACTIVE;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = push ? ACTIVE : EMPTY;

    ovf_d     = (new_frame ? 1'b0 : ovf_q) | drop;
    bad_d     = (new_frame ? 1'b0 : bad_q) | (wr_valid && !in_range);
    flushed_d = new_frame ? (flush ? cnt_q : '0) : flushed_q;
  end

  always_ff @(posedge clk_pixel) begin
    if (push) mem[wr_ptr_q] <= wr_cmd;
  end

  always_ff @(posedge clk_pixel or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
      flushed_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      ovf_q     <= ovf_d;
      bad_q     <= bad_d;
      flushed_q <= flushed_d;
    end
  end

  assign rd_valid      = (state_q != EMPTY);
  assign rd_x          = head_q.x;
  assign rd_y          = head_q.y;
  assign rd_frame      = head_q.f;
  assign count         = cnt_q;
  assign overflow      = ovf_q;
  assign bad_cmd       = bad_q;
  assign flushed_count = flushed_q;

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// Randomized + directed bench for sprite_cmd_queue against a queue-based reference model.
module tb_sprite_cmd_queue;

  logic       clk_pixel = 1'b0;
  logic       rst_n_in  = 1'b0;
  logic       new_frame = 1'b0;
  logic       wr_valid  = 1'b0;
  logic [8:0] wr_x      = '0;
  logic [9:0] wr_y      = '0;
  logic [4:0] wr_frame  = '0;
  logic       rd_ready  = 1'b0;
  logic       rd_valid;
  logic [8:0] rd_x;
  logic [9:0] rd_y;
  logic [4:0] rd_frame;
  logic [6:0] count;
  logic       overflow, bad_cmd;
  logic [6:0] flushed_count;

  sprite_cmd_queue dut (
    .clk_pixel(clk_pixel), .rst_n_in(rst_n_in), .new_frame(new_frame),
    .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_frame(wr_frame),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_x(rd_x), .rd_y(rd_y),
    .rd_frame(rd_frame), .count(count), .overflow(overflow), .bad_cmd(bad_cmd),
    .flushed_count(flushed_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {int x; int y; int f;} cmd_t;
  cmd_t mq[$];
  int   m_ovf, m_bad, m_flushed;
  int   total = 0, bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_bad = 0; m_flushed = 0;
  endtask

  // Spec rules: flush first (mode 1), then pop, then push against the pre-pop occupancy.
  task automatic model_step(input bit nf, input bit wv, input int x, input int y, input int f,
                            input bit rr);
    bit pop, inr, flushing;
    int sz;
    flushing = 0;
    if (nf) begin
      m_flushed = mq.size();
      m_ovf = 0; m_bad = 0;
      mq.delete();
      flushing = 1;
    end
    pop = (mq.size() > 0) && rr;
    sz  = mq.size();
    if (pop) void'(mq.pop_front());
    inr = (x < 360) && (y < 720) && (f < 18);
    if (wv) begin
      if (!inr) m_bad = 1;
      else if (sz < 64 || pop || flushing) mq.push_back('{x, y, f});
      else m_ovf = 1;
    end
  endtask

  task automatic check_all();
    chk("rd_valid", rd_valid, mq.size() > 0);
    chk("count", count, mq.size());
    if (mq.size() > 0) begin
      chk("rd_x", rd_x, mq[0].x);
      chk("rd_y", rd_y, mq[0].y);
      chk("rd_frame", rd_frame, mq[0].f);
    end
    chk("overflow", overflow, m_ovf);
    chk("bad_cmd", bad_cmd, m_bad);
    chk("flushed_count", flushed_count, m_flushed);
  endtask

  // Called at a negedge: drive, advance model, clock, check at next negedge.
  task automatic cyc(input bit nf, input bit wv, input int x, input int y, input int f,
                     input bit rr);
    new_frame = nf; wr_valid = wv; rd_ready = rr;
    wr_x = 9'(x); wr_y = 10'(y); wr_frame = 5'(f);
    model_step(nf, wv, x, y, f, rr);
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    check_all();
  endtask

  task automatic push(input int x, input int y, input int f, input bit rr);
    cyc(0, 1, x, y, f, rr);
  endtask

  task automatic idle(input bit rr);
    cyc(0, 0, 0, 0, 0, rr);
  endtask

  task automatic rnd_phase(input int n, input int pw, input int pr, input int pbad, input int pnf);
    int x, y, f, sel;
    for (int i = 0; i < n; i++) begin
      x = $urandom_range(0, 359); y = $urandom_range(0, 719); f = $urandom_range(0, 17);
      if ($urandom_range(0, 99) < pbad) begin
        sel = $urandom_range(0, 2);
        if (sel == 0) x = $urandom_range(360, 511);
        else if (sel == 1) y = $urandom_range(720, 1023);
        else f = $urandom_range(18, 31);
      end
      cyc($urandom_range(0, 999) < pnf, $urandom_range(0, 99) < pw, x, y, f,
          $urandom_range(0, 99) < pr);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_pixel);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset count", count, 0);
    chk("reset rd_x", rd_x, 0);
    chk("reset rd_y", rd_y, 0);
    chk("reset rd_frame", rd_frame, 0);
    chk("reset overflow", overflow, 0);
    chk("reset bad_cmd", bad_cmd, 0);
    chk("reset flushed", flushed_count, 0);
    rst_n_in = 1'b1;
    @(negedge clk_pixel);

    // single push, then hold with rd_ready low
    push(10, 20, 3, 0);
    repeat (5) idle(0);
    idle(1);

    // fill to 64, overflow on 65th, drain back-to-back
    for (int i = 0; i < 64; i++) push(i, i * 3, i % 18, 0);
    push(300, 300, 1, 0);
    chk("full overflow", overflow, 1);
    chk("full count", count, 64);
    for (int i = 0; i < 64; i++) idle(1);
    chk("drained", count, 0);

    // full queue with simultaneous push+pop across wrap
    for (int i = 0; i < 64; i++) push(100 + i, i, i % 18, 0);
    for (int i = 0; i < 10; i++) push(200 + i, 500 + i, 17, 1);
    chk("wrap count", count, 64);
    for (int i = 0; i < 64; i++) idle(1);

    // out-of-range commands
    push(5, 5, 5, 0);
    push(360, 0, 0, 0);
    push(0, 720, 0, 0);
    push(0, 0, 18, 0);
    chk("bad count", count, 1);
    chk("bad sticky", bad_cmd, 1);
    idle(1);

    // new_frame flush with simultaneous push and pop
    for (int i = 0; i < 7; i++) push(i + 40, i, 2, 0);
    push(0, 0, 31, 0);
    cyc(1, 1, 5, 6, 7, 1);
    chk("flush flushed", flushed_count, 7);
    chk("flush count", count, 1);
    chk("flush head x", rd_x, 5);
    chk("flush bad clr", bad_cmd, 0);
    idle(1);

    // new_frame with a same-cycle bad command keeps bad_cmd set
    cyc(1, 1, 400, 0, 0, 0);
    chk("nf bad recorded", bad_cmd, 1);

    // asynchronous reset mid-burst
    for (int i = 0; i < 10; i++) push(i, i, i, 0);
    #2 rst_n_in = 1'b0;
    #1;
    model_reset();
    chk("async rd_valid", rd_valid, 0);
    chk("async count", count, 0);
    chk("async overflow", overflow, 0);
    @(negedge clk_pixel);
    wr_valid = 1'b0; new_frame = 1'b0; rd_ready = 1'b0;
    rst_n_in = 1'b1;
    @(negedge clk_pixel);
    check_all();
    push(7, 8, 9, 0);
    idle(1);

    // randomized phases: fill-heavy, drain-heavy, balanced, error/frame-heavy
    rnd_phase(600, 90, 20, 3, 5);
    rnd_phase(400, 30, 90, 3, 5);
    rnd_phase(600, 60, 60, 5, 10);
    rnd_phase(400, 95, 95, 10, 30);
    rnd_phase(400, 80, 5, 2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
